// File: rtl/ddr_data_pkg.sv
// Shared widths and FSM state type for the DDR data core.
package ddr_data_pkg;

  localparam int unsigned GC_W       = 48;
  localparam int unsigned RNG_W      = 4;
  localparam int unsigned WORD_W     = 256;
  localparam int unsigned NSAMP      = WORD_W / RNG_W;
  localparam int unsigned CNT_W      = $clog2(NSAMP);
  localparam int unsigned FINE_W     = 16;
  localparam int unsigned GC_TDATA_W = FINE_W + GC_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2
  } state_e;

endpackage

// File: rtl/ddr_data_core_rng_packer.sv
// Packs RNG samples into WORD_W words, presents them on an AXI-Stream output
// register and flags dropped words (plus externally reported drops) in a sticky bit.
module rng_packer
  import ddr_data_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              sample_en,
  input  logic [RNG_W-1:0]  sample,
  input  logic              tready,
  input  logic              ovf_set,
  output logic [WORD_W-1:0] tdata,
  output logic              tvalid,
  output logic              overflow
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] full_word;
  logic [WORD_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              ovf_q, ovf_d;
  logic              word_done;
  logic              word_drop;
  int unsigned       sample_pos;

  assign sample_pos = RNG_W * int'(cnt_q);
  assign word_done  = sample_en && !clear && (cnt_q == CNT_W'(NSAMP - 1));

  always_comb begin
    full_word = word_q;
    full_word[sample_pos +: RNG_W] = sample;
  end

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d = '0;
    end else if (sample_en) begin
      word_d = full_word;
      cnt_d  = word_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // The last sample bypasses word_q so the word is visible one cycle after its final strobe.
  always_comb begin
    tvalid_d  = tvalid_q & ~tready;
    tdata_d   = tdata_q;
    word_drop = 1'b0;
    if (word_done) begin
      if (!tvalid_q || tready) begin
        tdata_d  = full_word;
        tvalid_d = 1'b1;
      end else begin
        word_drop = 1'b1;
      end
    end
    ovf_d = ovf_q | word_drop | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q    <= '0;
      word_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tdata    = tdata_q;
  assign tvalid   = tvalid_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/ddr_data_core.sv
// PPS-aligned global counter, click time-tagger and RNG word packer between the
// sample strobe domain and the host/DDR AXI-Stream links.
module ddr_data_core
  import ddr_data_pkg::*;
(
  input  logic                  clk200_i,
  input  logic                  ddr_data_rstn,
  input  logic                  pps_i,
  input  logic                  rd_en_4,
  input  logic [RNG_W-1:0]      rng_data,
  input  logic                  tvalid200,
  input  logic [FINE_W-1:0]     tdata200_mod,
  input  logic                  sr_start_write_ddr_i,
  input  logic                  sr_command_gc_enable,
  input  logic [GC_W-1:0]       sr_dq_gc_start_i,
  output logic [GC_W-1:0]       sr_current_dq_gc,
  output logic                  sr_overflow_o,
  output logic [WORD_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [GC_TDATA_W-1:0] m_axis_tdata_gc,
  output logic                  m_axis_tvalid_gc,
  input  logic                  m_axis_tready_gc
);

  state_e                  state_q, state_d;
  logic [GC_W-1:0]         gc_q, gc_d;
  logic                    pps_q, pps_q2;
  logic                    pps_rise;
  logic                    active;
  logic                    click;
  logic                    click_drop;
  logic                    gc_valid_q, gc_valid_d;
  logic [GC_TDATA_W-1:0]   gc_data_q, gc_data_d;

  // pps is asynchronous; edge detection runs on the registered copies only.
  assign pps_rise = pps_q & ~pps_q2;
  assign active   = (state_q == StRun) && sr_start_write_ddr_i;
  assign click    = active && sr_command_gc_enable && tvalid200;

  always_comb begin
    state_d = state_q;
    gc_d    = gc_q;
    unique case (state_q)
      StIdle: begin
        if (sr_start_write_ddr_i) state_d = StArmed;
      end
      StArmed: begin
        if (!sr_start_write_ddr_i) begin
          state_d = StIdle;
        end else if (pps_rise) begin
          state_d = StRun;
          gc_d    = sr_dq_gc_start_i;
        end
      end
      StRun: begin
        if (!sr_start_write_ddr_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (active && rd_en_4) gc_d = gc_q + GC_W'(1);
  end

  // Clicks are tagged with the pre-increment counter value.
  always_comb begin
    gc_valid_d = gc_valid_q & ~m_axis_tready_gc;
    gc_data_d  = gc_data_q;
    click_drop = 1'b0;
    if (click) begin
      if (!gc_valid_q || m_axis_tready_gc) begin
        gc_data_d  = {tdata200_mod, gc_q};
        gc_valid_d = 1'b1;
      end else begin
        click_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk200_i) begin
    if (!ddr_data_rstn) begin
      state_q    <= StIdle;
      gc_q       <= '0;
      pps_q      <= 1'b0;
      pps_q2     <= 1'b0;
      gc_valid_q <= 1'b0;
      gc_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      gc_q       <= gc_d;
      pps_q      <= pps_i;
      pps_q2     <= pps_q;
      gc_valid_q <= gc_valid_d;
      gc_data_q  <= gc_data_d;
    end
  end

  rng_packer u_rng_packer (
    .clk       (clk200_i),
    .rstn      (ddr_data_rstn),
    .clear     (!active),
    .sample_en (active && rd_en_4),
    .sample    (rng_data),
    .tready    (m_axis_tready),
    .ovf_set   (click_drop),
    .tdata     (m_axis_tdata),
    .tvalid    (m_axis_tvalid),
    .overflow  (sr_overflow_o)
  );

  assign sr_current_dq_gc = gc_q;
  assign m_axis_tdata_gc  = gc_data_q;
  assign m_axis_tvalid_gc = gc_valid_q;

endmodule

// File: tb/tb_ddr_data_core.sv
// Self-checking bench for ddr_data_core: directed literal scenarios plus a randomized
// run, all compared every cycle against a queue-based behavioural model.
module tb_ddr_data_core;

  logic         clk200_i = 1'b0;
  logic         ddr_data_rstn;
  logic         pps_i;
  logic         rd_en_4;
  logic [3:0]   rng_data;
  logic         tvalid200;
  logic [15:0]  tdata200_mod;
  logic         sr_start_write_ddr_i;
  logic         sr_command_gc_enable;
  logic [47:0]  sr_dq_gc_start_i;
  logic [47:0]  sr_current_dq_gc;
  logic         sr_overflow_o;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [63:0]  m_axis_tdata_gc;
  logic         m_axis_tvalid_gc;
  logic         m_axis_tready_gc;

  int checks = 0;
  int failures = 0;

  ddr_data_core dut (
    .clk200_i             (clk200_i),
    .ddr_data_rstn        (ddr_data_rstn),
    .pps_i                (pps_i),
    .rd_en_4              (rd_en_4),
    .rng_data             (rng_data),
    .tvalid200            (tvalid200),
    .tdata200_mod         (tdata200_mod),
    .sr_start_write_ddr_i (sr_start_write_ddr_i),
    .sr_command_gc_enable (sr_command_gc_enable),
    .sr_dq_gc_start_i     (sr_dq_gc_start_i),
    .sr_current_dq_gc     (sr_current_dq_gc),
    .sr_overflow_o        (sr_overflow_o),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tready        (m_axis_tready),
    .m_axis_tdata_gc      (m_axis_tdata_gc),
    .m_axis_tvalid_gc     (m_axis_tvalid_gc),
    .m_axis_tready_gc     (m_axis_tready_gc)
  );

  always #5 clk200_i = ~clk200_i;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Run phase: 0 idle, 1 waiting for pps, 2 running.
  int           m_phase;
  logic [47:0]  m_gc;
  logic [3:0]   m_samples[$];
  logic         m_tv, m_gv, m_ovf;
  logic [255:0] m_td, m_word;
  logic [63:0]  m_gd;
  logic         m_pps1, m_pps2;
  logic         m_rise, m_active;
  bit           model_ok = 0;

  always @(posedge clk200_i) begin
    model_ok = 1;
    if (!ddr_data_rstn) begin
      m_phase = 0; m_gc = '0; m_samples.delete();
      m_tv = 0; m_td = '0; m_gv = 0; m_gd = '0; m_ovf = 0;
      m_pps1 = 0; m_pps2 = 0;
    end else begin
      m_rise   = m_pps1 && !m_pps2;
      m_active = (m_phase == 2) && sr_start_write_ddr_i;
      if (m_tv && m_axis_tready) m_tv = 0;
      if (m_gv && m_axis_tready_gc) m_gv = 0;
      if (m_active && sr_command_gc_enable && tvalid200) begin
        if (!m_gv) begin m_gd = {tdata200_mod, m_gc}; m_gv = 1; end
        else m_ovf = 1;
      end
      if (m_active && rd_en_4) begin
        m_samples.push_back(rng_data);
        if (m_samples.size() == 64) begin
          for (int i = 0; i < 64; i++) m_word[i*4 +: 4] = m_samples[i];
          m_samples.delete();
          if (!m_tv) begin m_td = m_word; m_tv = 1; end
          else m_ovf = 1;
        end
        m_gc = m_gc + 48'd1;
      end
      if (!m_active) m_samples.delete();
      if (!sr_start_write_ddr_i) m_phase = 0;
      else if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1 && m_rise) begin m_phase = 2; m_gc = sr_dq_gc_start_i; end
      m_pps2 = m_pps1;
      m_pps1 = pps_i;
    end
  end

  always @(negedge clk200_i) begin
    if (model_ok) begin
      chk("dq_gc", 256'(sr_current_dq_gc), 256'(m_gc));
      chk("overflow", 256'(sr_overflow_o), 256'(m_ovf));
      chk("tvalid", 256'(m_axis_tvalid), 256'(m_tv));
      chk("tdata", m_axis_tdata, m_td);
      chk("tvalid_gc", 256'(m_axis_tvalid_gc), 256'(m_gv));
      chk("tdata_gc", 256'(m_axis_tdata_gc), 256'(m_gd));
    end
  end

  logic [255:0] beats[$];
  always @(posedge clk200_i) begin
    if (ddr_data_rstn && m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk200_i);
  endtask

  task automatic strobe(input logic [3:0] nib, input logic click, input logic [15:0] fine);
    rd_en_4 = 1; rng_data = nib; tvalid200 = click; tdata200_mod = fine;
    cyc();
    rd_en_4 = 0; tvalid200 = 0;
    repeat (4) cyc();
  endtask

  task automatic begin_run(input logic [47:0] v);
    sr_start_write_ddr_i = 0; pps_i = 0; rd_en_4 = 0;
    cyc(); cyc();
    sr_start_write_ddr_i = 1; sr_dq_gc_start_i = v;
    cyc(); cyc();
    pps_i = 1;
    repeat (3) cyc();
    chk("run_load", 256'(sr_current_dq_gc), 256'(v));
  endtask

  int           pps_cnt;
  int           ph;
  logic [63:0]  r64;
  logic [255:0] seq_word;

  initial begin
    ddr_data_rstn = 0; pps_i = 0; rd_en_4 = 0; rng_data = 0; tvalid200 = 0;
    tdata200_mod = 0; sr_start_write_ddr_i = 0; sr_command_gc_enable = 1;
    sr_dq_gc_start_i = '0; m_axis_tready = 1; m_axis_tready_gc = 1;
    repeat (2) cyc();
    chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("rst_tvalid_gc", 256'(m_axis_tvalid_gc), 256'(0));
    chk("rst_gc", 256'(sr_current_dq_gc), 256'(0));
    chk("rst_ovf", 256'(sr_overflow_o), 256'(0));
    ddr_data_rstn = 1;

    // Counter load on pps and increment on strobes.
    begin_run(48'h433);
    repeat (10) strobe(4'h0, 0, 16'h0);
    chk("gc_after_10", 256'(sr_current_dq_gc), 256'h43D);

    // Uniform word.
    begin_run(48'h1000);
    beats.delete();
    repeat (64) strobe(4'h2, 0, 16'h0);
    chk("beats_2s", 256'(beats.size()), 256'(1));
    if (beats.size() > 0) chk("word_2s", beats[0], {64{4'h2}});

    // Alternating groups of eight, first sample in the LSB.
    beats.delete();
    for (int i = 0; i < 64; i++) strobe(((i / 8) % 2 == 1) ? 4'h1 : 4'h0, 0, 16'h0);
    chk("beats_alt", 256'(beats.size()), 256'(1));
    if (beats.size() > 0) chk("word_alt", beats[0], {4{64'h1111_1111_0000_0000}});

    // Click coinciding with a strobe is tagged with the pre-increment counter.
    begin_run(48'h500);
    m_axis_tready_gc = 0;
    strobe(4'h0, 1, 16'h0017);
    chk("click_valid", 256'(m_axis_tvalid_gc), 256'(1));
    chk("click_data", 256'(m_axis_tdata_gc), 256'(64'h0017_0000_0000_0500));
    chk("click_gc", 256'(sr_current_dq_gc), 256'h501);
    m_axis_tready_gc = 1;
    cyc();

    // Counter wraps at 2^48.
    begin_run(48'hFFFF_FFFF_FFFE);
    repeat (3) strobe(4'h0, 0, 16'h0);
    chk("gc_wrap", 256'(sr_current_dq_gc), 256'h1);

    // Backpressure: first word held, second dropped, then stop mid-word.
    begin_run(48'h2000);
    m_axis_tready = 0;
    beats.delete();
    for (int i = 0; i < 64; i++) strobe(4'(i % 16), 0, 16'h0);
    seq_word = {4{64'hFEDC_BA98_7654_3210}};
    chk("held_valid", 256'(m_axis_tvalid), 256'(1));
    chk("held_ovf_clear", 256'(sr_overflow_o), 256'(0));
    for (int i = 0; i < 64; i++) strobe(4'hA, 0, 16'h0);
    chk("held_word", m_axis_tdata, seq_word);
    chk("drop_ovf", 256'(sr_overflow_o), 256'(1));
    repeat (20) strobe(4'h3, 0, 16'h0);
    sr_start_write_ddr_i = 0;
    cyc();
    repeat (10) strobe(4'h3, 0, 16'h0);
    chk("frozen_gc", 256'(sr_current_dq_gc), 256'h2094);
    chk("no_beats", 256'(beats.size()), 256'(0));

    // Randomized phase, checked by the per-cycle compare process.
    ddr_data_rstn = 0; m_axis_tready = 1;
    repeat (2) cyc();
    ddr_data_rstn = 1;
    pps_cnt = 50; ph = 0;
    for (int n = 0; n < 9000; n++) begin
      ddr_data_rstn = ($urandom_range(2999) != 0);
      if (sr_start_write_ddr_i) begin
        if ($urandom_range(1499) == 0) sr_start_write_ddr_i = 0;
      end else if ($urandom_range(19) == 0) begin
        sr_start_write_ddr_i = 1;
      end
      if (!sr_start_write_ddr_i) begin
        r64 = {$urandom, $urandom};
        sr_dq_gc_start_i = r64[47:0];
      end
      pps_cnt--;
      if (pps_cnt <= 0) begin
        pps_i = ~pps_i;
        pps_cnt = $urandom_range(300, 60);
      end
      ph = (ph == 4) ? 0 : ph + 1;
      rd_en_4 = (ph == 0) && ($urandom_range(9) != 0);
      rng_data = 4'($urandom_range(15));
      tvalid200 = ($urandom_range(6) == 0);
      tdata200_mod = 16'($urandom_range(624));
      sr_command_gc_enable = ($urandom_range(9) != 0);
      m_axis_tready = ($urandom_range(9) < 7);
      m_axis_tready_gc = ($urandom_range(9) < 6);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
